// File: rtl/bsk_led_stretch.sv
`default_nettype none
// ============================================================================
// Module   : bsk_led_stretch
// Brief    : Synchronises 32 command activity flags, stretches each to a
//            minimum on-time, and drives active-low LED vectors.
// Revision : 1.0 - initial release
// ============================================================================
module bsk_led_stretch #(
    parameter int CLK_DIV    = 1000,
    parameter int HOLD_TICKS = 100
) (
    input  logic        clk,
    input  logic        iRst,
    input  logic [15:0] iComPrd,
    input  logic [15:0] iComPrm,
    input  logic        iTest,
    output logic [15:0] oLedPrd,
    output logic [15:0] oLedPrm,
    output logic        oActive
);

    localparam int NCH = 32;
    localparam int DW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CW  = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
    localparam logic [DW-1:0] c_DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] c_HOLD     = CW'(HOLD_TICKS);

    logic [NCH-1:0] meta_q;
    logic [NCH-1:0] sync_q;
    logic [DW-1:0]  div_q;
    logic [DW-1:0]  div_d;
    logic           tick;
    logic [NCH-1:0] lit;
    logic [NCH-1:0] on_q;
    logic [NCH-1:0] on_d;
    logic           active_q;
    logic           active_d;

    // Bit order: [15:0] transmitter, [31:16] receiver.
    always_ff @(posedge clk or posedge iRst) begin
        if (iRst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= {iComPrm, iComPrd};
            sync_q <= meta_q;
        end
    end

    always_comb begin
        tick  = (div_q == c_DIV_LAST);
        div_d = tick ? '0 : div_q + DW'(1);
    end

    always_ff @(posedge clk or posedge iRst) begin
        if (iRst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    for (genvar n = 0; n < NCH; n++) begin : g_ch
        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;

        // A live flag reloads every cycle, so it wins over a coincident tick.
        always_comb begin
            cnt_d = cnt_q;
            if (sync_q[n]) begin
                cnt_d = c_HOLD;
            end else if (tick && (cnt_q != '0)) begin
                cnt_d = cnt_q - CW'(1);
            end
        end

        always_ff @(posedge clk or posedge iRst) begin
            if (iRst) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign lit[n] = sync_q[n] | (cnt_q != '0);
    end

    always_comb begin
        on_d     = lit | {NCH{iTest}};
        active_d = |lit;
    end

    always_ff @(posedge clk or posedge iRst) begin
        if (iRst) begin
            on_q     <= '0;
            active_q <= 1'b0;
        end else begin
            on_q     <= on_d;
            active_q <= active_d;
        end
    end

    assign oLedPrd = ~on_q[15:0];
    assign oLedPrm = ~on_q[31:16];
    assign oActive = active_q;

endmodule
`default_nettype wire

// File: tb/tb_bsk_led_stretch.sv
`default_nettype none
// ============================================================================
// Module   : tb_bsk_led_stretch
// Brief    : Directed self-checking bench for bsk_led_stretch (CLK_DIV=4,
//            HOLD_TICKS=3, so stretch ends 10..13 clk after sync fall).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bsk_led_stretch;

    logic        clk     = 1'b0;
    logic        clk_en  = 1'b0;
    logic        iRst    = 1'b0;
    logic [15:0] iComPrd = 16'h0000;
    logic [15:0] iComPrm = 16'h0000;
    logic        iTest   = 1'b0;
    logic [15:0] oLedPrd;
    logic [15:0] oLedPrm;
    logic        oActive;

    int n_chk  = 0;
    int n_fail = 0;

    bsk_led_stretch #(
        .CLK_DIV    (4),
        .HOLD_TICKS (3)
    ) dut (
        .clk     (clk),
        .iRst    (iRst),
        .iComPrd (iComPrd),
        .iComPrm (iComPrm),
        .iTest   (iTest),
        .oLedPrd (oLedPrd),
        .oLedPrm (oLedPrm),
        .oActive (oActive)
    );

    initial begin
        wait (clk_en);
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        #1 iRst = 1'b1;
        #2;
        n_chk++;
        if (oLedPrd !== 16'hFFFF || oLedPrm !== 16'hFFFF || oActive !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_noclk: prd=%h prm=%h act=%b want FFFF FFFF 0", oLedPrd, oLedPrm, oActive);
        end
        clk_en = 1'b1;
        idle(3);
        #2 iRst = 1'b0;
        idle(5);
        n_chk++;
        if (oLedPrd !== 16'hFFFF || oLedPrm !== 16'hFFFF || oActive !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: prd=%h prm=%h act=%b want FFFF FFFF 0", oLedPrd, oLedPrm, oActive);
        end
    endtask

    task automatic test_pulse();
        int k_off;
        k_off = -1;
        iComPrd = 16'h0001;
        step();
        iComPrd = 16'h0000;
        step();
        n_chk++;
        if (oLedPrd !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL pulse_early: prd=%h want FFFF after 2 clk", oLedPrd);
        end
        step();
        n_chk++;
        if (oLedPrd !== 16'hFFFE || oActive !== 1'b1) begin
            n_fail++;
            $display("FAIL pulse_on: prd=%h act=%b want FFFE 1", oLedPrd, oActive);
        end
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k_off < 0 && oLedPrd == 16'hFFFF) k_off = k;
            n_chk++;
            if (oLedPrd[15:1] !== 15'h7FFF || oLedPrm !== 16'hFFFF) begin
                n_fail++;
                $display("FAIL pulse_others: k=%0d prd=%h prm=%h want other bits 1", k, oLedPrd, oLedPrm);
            end
            n_chk++;
            if (oActive !== (k_off < 0)) begin
                n_fail++;
                $display("FAIL pulse_active: k=%0d act=%b want %b", k, oActive, (k_off < 0));
            end
        end
        n_chk++;
        if (k_off < 10 || k_off > 13) begin
            n_fail++;
            $display("FAIL pulse_offtime: off after %0d clk want 10..13", k_off);
        end
    endtask

    task automatic test_hold();
        int k_off;
        k_off = -1;
        iComPrm = 16'h8000;
        for (int t = 1; t <= 100; t++) begin
            step();
            if (t >= 3) begin
                n_chk++;
                if (oLedPrm !== 16'h7FFF || oLedPrd !== 16'hFFFF) begin
                    n_fail++;
                    $display("FAIL hold_steady: t=%0d prm=%h prd=%h want 7FFF FFFF", t, oLedPrm, oLedPrd);
                end
            end
        end
        iComPrm = 16'h0000;
        idle(2);
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k_off < 0 && oLedPrm == 16'hFFFF) k_off = k;
        end
        n_chk++;
        if (k_off < 10 || k_off > 13) begin
            n_fail++;
            $display("FAIL hold_offtime: off after %0d clk want 10..13", k_off);
        end
    endtask

    task automatic test_retrigger();
        iComPrd = 16'h0008;
        for (int t = 1; t <= 30; t++) begin
            step();
            iComPrd = (t == 6) ? 16'h0008 : 16'h0000;
            if (t >= 3 && t <= 18) begin
                n_chk++;
                if (oLedPrd !== 16'hFFF7) begin
                    n_fail++;
                    $display("FAIL retrig_on: t=%0d prd=%h want FFF7", t, oLedPrd);
                end
            end
            if (t >= 22) begin
                n_chk++;
                if (oLedPrd !== 16'hFFFF) begin
                    n_fail++;
                    $display("FAIL retrig_off: t=%0d prd=%h want FFFF", t, oLedPrd);
                end
            end
        end
    endtask

    task automatic test_lamp();
        iComPrm = 16'h0004;
        step();
        iComPrm = 16'h0000;
        idle(2);
        iTest = 1'b1;
        for (int t = 1; t <= 5; t++) begin
            step();
            n_chk++;
            if (oLedPrd !== 16'h0000 || oLedPrm !== 16'h0000 || oActive !== 1'b1) begin
                n_fail++;
                $display("FAIL lamp_on: t=%0d prd=%h prm=%h act=%b want 0000 0000 1", t, oLedPrd, oLedPrm, oActive);
            end
        end
        iTest = 1'b0;
        step();
        n_chk++;
        if (oLedPrd !== 16'hFFFF || oLedPrm !== 16'hFFFB || oActive !== 1'b1) begin
            n_fail++;
            $display("FAIL lamp_release: prd=%h prm=%h act=%b want FFFF FFFB 1", oLedPrd, oLedPrm, oActive);
        end
        idle(12);
        n_chk++;
        if (oLedPrm !== 16'hFFFF || oActive !== 1'b0) begin
            n_fail++;
            $display("FAIL lamp_expire: prm=%h act=%b want FFFF 0", oLedPrm, oActive);
        end
        iTest = 1'b1;
        step();
        n_chk++;
        if (oLedPrd !== 16'h0000 || oLedPrm !== 16'h0000 || oActive !== 1'b0) begin
            n_fail++;
            $display("FAIL lamp_idle: prd=%h prm=%h act=%b want 0000 0000 0", oLedPrd, oLedPrm, oActive);
        end
        iTest = 1'b0;
        step();
    endtask

    task automatic test_async_reset();
        iComPrd = 16'hA5A5;
        step();
        iComPrd = 16'h0000;
        idle(2);
        n_chk++;
        if (oLedPrd !== 16'h5A5A || oActive !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_pre: prd=%h act=%b want 5A5A 1", oLedPrd, oActive);
        end
        idle(2);
        #3 iRst = 1'b1;
        #1;
        n_chk++;
        if (oLedPrd !== 16'hFFFF || oLedPrm !== 16'hFFFF || oActive !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_now: prd=%h prm=%h act=%b want FFFF FFFF 0", oLedPrd, oLedPrm, oActive);
        end
        idle(2);
        #2 iRst = 1'b0;
        for (int t = 1; t <= 4; t++) begin
            step();
            n_chk++;
            if (oLedPrd !== 16'hFFFF || oActive !== 1'b0) begin
                n_fail++;
                $display("FAIL arst_residual: t=%0d prd=%h act=%b want FFFF 0", t, oLedPrd, oActive);
            end
        end
    endtask

    initial begin
        test_reset();
        test_pulse();
        idle(20);
        test_hold();
        idle(20);
        test_retrigger();
        idle(20);
        test_lamp();
        idle(20);
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
